sobel_3x3_edge_detect: RTL

//  Downstream consumer of the 3x3 window generator. Computes Sobel gradient magnitude |Gx|+|Gy| per pixel.

---
 rtl/sobel_3x3_edge_detect_pkg.sv | 18 +
 rtl/sobel_3x3_edge_detect_if.sv | 33 +++
 rtl/sobel_3x3_edge_detect_abs_diff.sv | 12 +
 rtl/sobel_3x3_edge_detect.sv | 118 +++++++++++
 4 files changed

// File: rtl/sobel_3x3_edge_detect_pkg.sv
// Shared constants, sync bundle type and saturation helper for the Sobel edge detector.
package sobel_3x3_edge_detect_pkg;

  localparam int unsigned SOBEL_LAT = 3;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic valid;
  } sobel_sync_t;

  function automatic logic [31:0] sobel_sat(input logic [31:0] mag, input int unsigned width);
    logic [31:0] lim;
    lim = (32'd1 << width) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/sobel_3x3_edge_detect_if.sv
// 3x3 window bus from the window generator: syncs, border flags and nine taps.
interface sobel_3x3_edge_detect_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  matrix_img_vsync;
  logic                  matrix_img_hsync;
  logic                  matrix_img_valid;
  logic                  matrix_top_edge_flag;
  logic                  matrix_bottom_edge_flag;
  logic                  matrix_left_edge_flag;
  logic                  matrix_right_edge_flag;
  logic [DATA_WIDTH-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DATA_WIDTH-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DATA_WIDTH-1:0] matrix_p31, matrix_p32, matrix_p33;

  modport master (
    output matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
    output matrix_top_edge_flag, matrix_bottom_edge_flag,
    output matrix_left_edge_flag, matrix_right_edge_flag,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33
  );

  modport slave (
    input matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
    input matrix_top_edge_flag, matrix_bottom_edge_flag,
    input matrix_left_edge_flag, matrix_right_edge_flag,
    input matrix_p11, matrix_p12, matrix_p13,
    input matrix_p21, matrix_p22, matrix_p23,
    input matrix_p31, matrix_p32, matrix_p33
  );
endinterface

// File: rtl/sobel_3x3_edge_detect_abs_diff.sv
// Unsigned absolute difference, used for |Gx| and |Gy|.
module sobel_abs_diff #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);
  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
  end
endmodule

// File: rtl/sobel_3x3_edge_detect.sv
// Three-stage Sobel |Gx|+|Gy| with border suppression, optional binary threshold
// and a per-frame edge pixel counter.
module sobel_3x3_edge_detect
  import sobel_3x3_edge_detect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          BINARY_OUT = 1'b1,
  parameter int unsigned CNT_WIDTH  = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sobel_3x3_edge_detect_if.slave  win,
  input  logic [DATA_WIDTH-1:0]   edge_threshold,
  output logic                    post_img_vsync,
  output logic                    post_img_hsync,
  output logic                    post_img_valid,
  output logic [DATA_WIDTH-1:0]   post_img_data,
  output logic [CNT_WIDTH-1:0]    frame_edge_cnt
);
  localparam int unsigned SW = DATA_WIDTH + 2;
  localparam int unsigned MW = DATA_WIDTH + 3;

  function automatic logic [SW-1:0] tap_sum(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b,
                                            input logic [DATA_WIDTH-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  sobel_sync_t [SOBEL_LAT-1:0] sync_sr;
  sobel_sync_t                 sync_in;
  logic                        border_in, border_s1, border_s2;
  logic [SW-1:0]               gx_p, gx_n, gy_p, gy_n;
  logic [SW-1:0]               gx_abs, gy_abs, gx_abs_s2, gy_abs_s2;
  logic [DATA_WIDTH-1:0]       thr_latched;
  logic                        vsync_d;
  logic [CNT_WIDTH-1:0]        run_cnt;
  logic [MW-1:0]               mag;
  logic [DATA_WIDTH-1:0]       sat, data_next;
  logic                        hit, keep, count_inc, post_vsync_rise;

  always_comb begin
    sync_in.vsync = win.matrix_img_vsync;
    sync_in.hsync = win.matrix_img_hsync;
    sync_in.valid = win.matrix_img_valid;
    border_in     = win.matrix_top_edge_flag  | win.matrix_bottom_edge_flag |
                    win.matrix_left_edge_flag | win.matrix_right_edge_flag;
  end

  sobel_abs_diff #(.WIDTH(SW)) u_abs_gx (.a(gx_p), .b(gx_n), .diff(gx_abs));
  sobel_abs_diff #(.WIDTH(SW)) u_abs_gy (.a(gy_p), .b(gy_n), .diff(gy_abs));

  always_comb begin
    mag       = MW'(gx_abs_s2) + MW'(gy_abs_s2);
    sat       = DATA_WIDTH'(sobel_sat(32'(mag), DATA_WIDTH));
    hit       = (sat >= thr_latched);
    keep      = sync_sr[1].valid && !border_s2;
    count_inc = keep && hit;
    data_next = '0;
    if (keep) begin
      if (!BINARY_OUT) begin
        data_next = sat;
      end else if (hit) begin
        data_next = '1;
      end
    end
  end

  // Frame boundary is taken where vsync is about to rise on the output, so the
  // pixel leaving stage 3 on that same edge belongs to the new frame.
  assign post_vsync_rise = sync_sr[1].vsync && !sync_sr[2].vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr        <= '0;
      border_s1      <= 1'b0;
      border_s2      <= 1'b0;
      gx_p           <= '0;
      gx_n           <= '0;
      gy_p           <= '0;
      gy_n           <= '0;
      gx_abs_s2      <= '0;
      gy_abs_s2      <= '0;
      post_img_data  <= '0;
      thr_latched    <= '1;
      vsync_d        <= 1'b0;
      run_cnt        <= '0;
      frame_edge_cnt <= '0;
    end else begin
      sync_sr   <= {sync_sr[SOBEL_LAT-2:0], sync_in};
      border_s1 <= border_in;
      border_s2 <= border_s1;
      gx_p      <= tap_sum(win.matrix_p13, win.matrix_p23, win.matrix_p33);
      gx_n      <= tap_sum(win.matrix_p11, win.matrix_p21, win.matrix_p31);
      gy_p      <= tap_sum(win.matrix_p31, win.matrix_p32, win.matrix_p33);
      gy_n      <= tap_sum(win.matrix_p11, win.matrix_p12, win.matrix_p13);
      gx_abs_s2 <= gx_abs;
      gy_abs_s2 <= gy_abs;
      post_img_data <= data_next;

      vsync_d <= win.matrix_img_vsync;
      if (win.matrix_img_vsync && !vsync_d) begin
        thr_latched <= edge_threshold;
      end

      if (post_vsync_rise) begin
        frame_edge_cnt <= run_cnt;
        run_cnt        <= count_inc ? CNT_WIDTH'(1) : '0;
      end else if (count_inc && (run_cnt != '1)) begin
        run_cnt <= run_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign post_img_vsync = sync_sr[2].vsync;
  assign post_img_hsync = sync_sr[2].hsync;
  assign post_img_valid = sync_sr[2].valid;

endmodule
